// File: rtl/i2c_target.sv
// Single-address I2C-style target for the LC3 serial bus.
// Open-drain SDA via sda_oe; byte-parallel write and read paths.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_AACK  = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_WACK  = 3'd4;
    localparam logic [2:0] S_RD    = 3'd5;
    localparam logic [2:0] S_RACK  = 3'd6;
    localparam logic [2:0] S_WSTOP = 3'd7;

    // [0],[1] synchronizer, [2] edge-detect delay; all idle-high
    logic [2:0] scl_q, sda_q;
    logic       start_q, stop_q, rise_q, fall_q;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       rx_valid_q, rx_valid_d;
    logic       sda_b;

    assign sda_b = sda_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q   <= 3'b111;
            sda_q   <= 3'b111;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            scl_q   <= {scl_q[1:0], scl_in};
            sda_q   <= {sda_q[1:0], sda_in};
            start_q <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
            stop_q  <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
            rise_q  <= scl_q[1] & ~scl_q[2];
            fall_q  <= ~scl_q[1] & scl_q[2];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rx_data_d  = rx_data_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        tx_req     = 1'b0;
        if (stop_q) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
        end else if (start_q) begin
            state_d = S_ADDR;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (rise_q) begin
                        sh_d  = {sh_q[6:0], sda_b};
                        cnt_d = cnt_q + 4'd1;
                    end else if (fall_q && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        if (sh_q[7:1] == ADDR) begin
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = sh_q[0];
                            state_d = S_AACK;
                        end else begin
                            state_d = S_WSTOP;
                        end
                    end
                end
                S_AACK: begin
                    if (fall_q) begin
                        oe_d  = 1'b0;
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            tx_req  = 1'b1;
                            sh_d    = tx_data;
                            oe_d    = ~tx_data[7];
                            state_d = S_RD;
                        end else begin
                            state_d = S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (rise_q) begin
                        sh_d  = {sh_q[6:0], sda_b};
                        cnt_d = cnt_q + 4'd1;
                    end else if (fall_q && cnt_q == 4'd8) begin
                        rx_data_d  = sh_q;
                        rx_valid_d = 1'b1;
                        oe_d       = 1'b1;
                        state_d    = S_WACK;
                    end
                end
                S_WACK: begin
                    if (fall_q) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_WR;
                    end
                end
                S_RD: begin
                    if (rise_q) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (fall_q) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = S_RACK;
                        end else begin
                            sh_d = {sh_q[6:0], 1'b0};
                            oe_d = ~sh_q[6];
                        end
                    end
                end
                S_RACK: begin
                    // a fall here always follows an ACK sampled on the rise
                    if (rise_q && sda_b) begin
                        busy_d  = 1'b0;
                        state_d = S_WSTOP;
                    end else if (fall_q) begin
                        tx_req  = 1'b1;
                        sh_d    = tx_data;
                        oe_d    = ~tx_data[7];
                        cnt_d   = 4'd0;
                        state_d = S_RD;
                    end
                end
                S_IDLE, S_WSTOP: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rx_data_q  <= rx_data_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sda_oe   = oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: write, read, mismatch, repeated START,
// abort and mid-read reset, driven by a simple bit-banged initiator.
module tb_i2c_target;

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    int nvec;
    int nerr;
    int rx_cnt;
    int tx_cnt;
    int oe_cnt;
    int busy_cnt;
    int both_cnt;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target #(.ADDR(7'h50)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rx_cnt = 0; tx_cnt = 0; oe_cnt = 0; busy_cnt = 0; both_cnt = 0;
    end

    always @(posedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rx_valid && tx_req) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, output logic rd, output logic oe);
        tick(2);
        sda_m = b;
        tick(6);
        scl_m = 1'b1;
        tick(4);
        rd = sda_bus;
        oe = sda_oe;
        tick(4);
        scl_m = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        tick(6);
        scl_m = 1'b1;
        tick(8);
        sda_m = 1'b0;
        tick(8);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        tick(2);
        sda_m = 1'b0;
        tick(6);
        scl_m = 1'b1;
        tick(8);
        sda_m = 1'b1;
        tick(8);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic r, o;
        for (int i = 7; i >= 0; i--) sbit(b[i], r, o);
        sbit(1'b1, r, o);
        ack = o;
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r, o;
        for (int i = 7; i >= 0; i--) begin
            sbit(1'b1, r, o);
            d[i] = r;
        end
        sbit(nack, r, o);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tx0, oe0, bz0;
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tx_data = 8'h00;
        tick(3);
        chk("rst_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_txr", tx_req, 0);
        chk("rst_rxd", rx_data, 8'h00);
        rst = 1'b0;
        tick(6);

        // write A0, 3C, C5
        rx0 = rx_cnt;
        bus_start();
        wbyte(8'hA0, ack);
        chk("wr_aack", ack, 1);
        chk("wr_busy", busy, 1);
        wbyte(8'h3C, ack);
        chk("wr_ack1", ack, 1);
        chk("wr_d1", rx_data, 8'h3C);
        wbyte(8'hC5, ack);
        chk("wr_ack2", ack, 1);
        chk("wr_d2", rx_data, 8'hC5);
        chk("wr_nrx", rx_cnt - rx0, 2);
        bus_stop();
        chk("wr_busy_stop", busy, 0);
        chk("wr_oe_stop", sda_oe, 0);

        // read 96 (ACK), 5A (NACK)
        tx0 = tx_cnt;
        tx_data = 8'h96;
        bus_start();
        wbyte(8'hA1, ack);
        chk("rd_aack", ack, 1);
        rbyte(1'b0, d);
        tx_data = 8'h5A;
        chk("rd_b1", d, 8'h96);
        rbyte(1'b1, d);
        chk("rd_b2", d, 8'h5A);
        chk("rd_ntx", tx_cnt - tx0, 2);
        tick(2);
        chk("rd_oe_end", sda_oe, 0);
        chk("rd_busy_nack", busy, 0);
        bus_stop();

        // address mismatch
        rx0 = rx_cnt; oe0 = oe_cnt; bz0 = busy_cnt;
        bus_start();
        wbyte(8'hA2, ack);
        chk("mm_ack", ack, 0);
        wbyte(8'hFF, ack);
        chk("mm_ack2", ack, 0);
        bus_stop();
        chk("mm_oe", oe_cnt - oe0, 0);
        chk("mm_rx", rx_cnt - rx0, 0);
        chk("mm_busy", busy_cnt - bz0, 0);

        // repeated START into a read
        bus_start();
        wbyte(8'hA0, ack);
        chk("rs_aack", ack, 1);
        wbyte(8'h11, ack);
        chk("rs_ack", ack, 1);
        chk("rs_rxd", rx_data, 8'h11);
        tx_data = 8'h77;
        bus_start();
        chk("rs_oe", sda_oe, 0);
        chk("rs_busy", busy, 0);
        wbyte(8'hA1, ack);
        chk("rs_raack", ack, 1);
        rbyte(1'b1, d);
        chk("rs_rd", d, 8'h77);
        bus_stop();

        // abort mid-byte with STOP
        bus_start();
        wbyte(8'hA0, ack);
        chk("ab_aack", ack, 1);
        rx0 = rx_cnt;
        begin
            logic r, o;
            sbit(1'b1, r, o);
            sbit(1'b0, r, o);
            sbit(1'b1, r, o);
            sbit(1'b1, r, o);
        end
        bus_stop();
        chk("ab_rx", rx_cnt - rx0, 0);
        chk("ab_oe", sda_oe, 0);
        chk("ab_busy", busy, 0);
        bus_start();
        wbyte(8'hA0, ack);
        chk("ab_reack", ack, 1);
        bus_stop();

        // reset while driving a 0 data bit
        tx_data = 8'h00;
        bus_start();
        wbyte(8'hA1, ack);
        chk("rr_aack", ack, 1);
        tick(6);
        chk("rr_oe_pre", sda_oe, 1);
        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(1);
        chk("rr_oe", sda_oe, 0);
        chk("rr_busy", busy, 0);
        rst = 1'b0;
        oe0 = oe_cnt; bz0 = busy_cnt;
        tick(20);
        chk("rr_idle_oe", oe_cnt - oe0, 0);
        chk("rr_idle_busy", busy_cnt - bz0, 0);
        bus_start();
        wbyte(8'hA0, ack);
        chk("rr_wack", ack, 1);
        bus_stop();

        chk("rxv_txr_excl", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
